// File: rtl/perf_counter_bank.sv
// Bank of wide hardware performance counters with per-counter inhibit, sticky
// overflow flags and a registered 32-bit read port with a lo/hi shadow for tear-free reads.
module perf_counter_bank #(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 48,
  parameter int INC_W        = 2,
  localparam int SEL_W       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_COUNTERS*INC_W-1:0] event_inc,
  input  logic [NUM_COUNTERS-1:0]       inhibit,
  input  logic                          wr_en,
  input  logic [SEL_W-1:0]              wr_sel,
  input  logic                          wr_hi,
  input  logic [31:0]                   wr_data,
  input  logic                          rd_en,
  input  logic [SEL_W-1:0]              rd_sel,
  input  logic                          rd_hi,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  input  logic [NUM_COUNTERS-1:0]       ovf_clr,
  output logic [NUM_COUNTERS-1:0]       overflow
);

  localparam int HI_W = COUNTER_W - 32;

  logic [COUNTER_W-1:0] cnt_all [NUM_COUNTERS];
  logic [COUNTER_W-1:0] rd_cnt;
  logic                 rd_hit;
  logic [HI_W-1:0]      shadow;
  logic [SEL_W-1:0]     shadow_sel;
  logic [SEL_W-1:0]     cap_sel;
  logic                 shadow_vld;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ctr
    logic                 wr_hit;
    logic [INC_W-1:0]     inc;
    logic [COUNTER_W:0]   sum;
    logic [COUNTER_W-1:0] cnt;
    logic                 ovf;

    assign wr_hit = wr_en && (wr_sel == SEL_W'(i));
    assign inc    = event_inc[i*INC_W +: INC_W];
    assign sum    = {1'b0, cnt} + (COUNTER_W+1)'(inc);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        // A write replaces only one half and drops this cycle's increment.
        if (wr_hit) begin
          if (wr_hi) cnt[COUNTER_W-1:32] <= wr_data[HI_W-1:0];
          else       cnt[31:0]           <= wr_data;
        end else if (!inhibit[i]) begin
          cnt <= sum[COUNTER_W-1:0];
        end
        if (!wr_hit && !inhibit[i] && sum[COUNTER_W]) ovf <= 1'b1;
        else if (ovf_clr[i])                          ovf <= 1'b0;
      end
    end

    assign cnt_all[i]  = cnt;
    assign overflow[i] = ovf;
  end

  always_comb begin
    rd_cnt = '0;
    rd_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_COUNTERS; j++) begin
      if (rd_sel == SEL_W'(j)) begin
        rd_cnt = cnt_all[j];
        rd_hit = 1'b1;
      end
    end
  end

  // Selector the shadow will hold after this edge; a write to it invalidates the capture.
  assign cap_sel = (rd_en && rd_hit && !rd_hi) ? rd_sel : shadow_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      shadow     <= '0;
      shadow_sel <= '0;
      shadow_vld <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (!rd_hit) begin
          rd_data <= '0;
        end else if (!rd_hi) begin
          rd_data    <= rd_cnt[31:0];
          shadow     <= rd_cnt[COUNTER_W-1:32];
          shadow_sel <= rd_sel;
          shadow_vld <= 1'b1;
        end else if (shadow_vld && (shadow_sel == rd_sel)) begin
          rd_data    <= 32'(shadow);
          shadow_vld <= 1'b0;
        end else begin
          rd_data <= 32'(rd_cnt[COUNTER_W-1:32]);
        end
      end
      if (wr_en && (wr_sel == cap_sel)) shadow_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: read expectations are queued when the
// read is issued and compared when rd_valid returns.
module tb_perf_counter_bank;

  localparam int N  = 4;
  localparam int CW = 48;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*IW-1:0] event_inc;
  logic [N-1:0]  inhibit;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic          wr_hi;
  logic [31:0]   wr_data;
  logic          rd_en;
  logic [1:0]    rd_sel;
  logic          rd_hi;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [N-1:0]  ovf_clr;
  logic [N-1:0]  overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  perf_counter_bank #(.NUM_COUNTERS(N), .COUNTER_W(CW), .INC_W(IW)) dut (
    .clk(clk), .rst(rst), .event_inc(event_inc), .inhibit(inhibit),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data),
    .rd_valid(rd_valid), .ovf_clr(ovf_clr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic was_rd;
    was_rd = rd_en && !rst;
    @(posedge clk);
    #1;
    check("rd_valid", 64'(rd_valid), 64'(was_rd));
    if (was_rd) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: got rd_data %h with no expectation queued", rd_data);
      end else begin
        check(tag_q.pop_front(), 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic set_inc(input int idx, input logic [IW-1:0] v);
    event_inc[idx*IW +: IW] = v;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic hi, input logic [31:0] exp);
    rd_en = 1'b1; rd_sel = sel; rd_hi = hi;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic hi, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_hi = hi; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; event_inc = '1; inhibit = '0; wr_en = 1'b0; wr_sel = '0; wr_hi = 1'b0;
    wr_data = '0; rd_en = 1'b1; rd_sel = '0; rd_hi = 1'b0; ovf_clr = '0;

    // reset held two cycles with full increments and a read request
    tick();
    tick();
    check("ovf_reset", 64'(overflow), 64'd0);
    rst = 1'b0; event_inc = '0; rd_en = 1'b0;
    rd("rst_ctr0_lo", 2'd0, 1'b0, 32'h0);
    rd("rst_ctr3_lo", 2'd3, 1'b0, 32'h0);
    rd("rst_ctr3_hi", 2'd3, 1'b1, 32'h0);

    // count then inhibit
    set_inc(1, 2'd2);
    repeat (10) tick();
    inhibit[1] = 1'b1; set_inc(1, 2'd3);
    repeat (5) tick();
    inhibit = '0; set_inc(1, 2'd0);
    rd("cnt_inhibit", 2'd1, 1'b0, 32'd20);

    // wrap sets overflow; writes leave it alone; set beats same-cycle clear
    wr(2'd0, 1'b1, 32'h0000_FFFF);
    wr(2'd0, 1'b0, 32'hFFFF_FFFE);
    set_inc(0, 2'd3);
    tick();
    set_inc(0, 2'd0);
    check("ovf_wrap", 64'(overflow), 64'b0001);
    rd("wrap_lo", 2'd0, 1'b0, 32'h1);
    rd("wrap_hi", 2'd0, 1'b1, 32'h0);
    wr(2'd0, 1'b1, 32'h0000_FFFF);
    wr(2'd0, 1'b0, 32'hFFFF_FFFF);
    check("ovf_after_wr", 64'(overflow), 64'b0001);
    set_inc(0, 2'd1); ovf_clr[0] = 1'b1;
    tick();
    set_inc(0, 2'd0);
    check("ovf_set_wins", 64'(overflow), 64'b0001);
    tick();
    ovf_clr = '0;
    check("ovf_clr", 64'(overflow), 64'b0000);
    rd("wrap2_lo", 2'd0, 1'b0, 32'h0);

    // inhibited counter at max never wraps
    wr(2'd1, 1'b1, 32'h0000_FFFF);
    wr(2'd1, 1'b0, 32'hFFFF_FFFF);
    inhibit[1] = 1'b1; set_inc(1, 2'd3);
    tick();
    inhibit = '0; set_inc(1, 2'd0);
    check("ovf_inhibit", 64'(overflow), 64'b0000);
    rd("inhibit_max", 2'd1, 1'b0, 32'hFFFF_FFFF);

    // tear-free lo/hi through the shadow
    wr(2'd2, 1'b1, 32'h0);
    wr(2'd2, 1'b0, 32'hFFFF_FFFF);
    set_inc(2, 2'd1);
    rd("tear_lo", 2'd2, 1'b0, 32'hFFFF_FFFF);
    rd("tear_shadow_hi", 2'd2, 1'b1, 32'h0);
    rd("tear_live_hi", 2'd2, 1'b1, 32'h1);
    set_inc(2, 2'd0);
    rd("shadow_lo", 2'd2, 1'b0, 32'h2);
    wr(2'd2, 1'b1, 32'h7);
    rd("shadow_inval_hi", 2'd2, 1'b1, 32'h7);

    // write priority over increment, other half untouched, high-word truncation
    wr(2'd3, 1'b1, 32'h12);
    set_inc(3, 2'd3);
    wr(2'd3, 1'b0, 32'h100);
    set_inc(3, 2'd0);
    rd("wprio_lo", 2'd3, 1'b0, 32'h100);
    rd("wprio_hi", 2'd3, 1'b1, 32'h12);
    wr(2'd3, 1'b1, 32'hFFFF_FFFF);
    rd("hi_trunc", 2'd3, 1'b1, 32'h0000_FFFF);
    rd("hi_trunc_lo", 2'd3, 1'b0, 32'h100);

    // same-cycle read and write of ctr0 while counting
    set_inc(0, 2'd1);
    wr_en = 1'b1; wr_sel = 2'd0; wr_hi = 1'b0; wr_data = 32'h55;
    rd("rdwr_old", 2'd0, 1'b0, 32'h0);
    wr_en = 1'b0;
    rd("rdwr_new", 2'd0, 1'b0, 32'h55);
    set_inc(0, 2'd0);
    rd("rdwr_cnt", 2'd0, 1'b0, 32'h56);

    // reset squashes a same-cycle read and clears all state
    set_inc(3, 2'd3);
    rst = 1'b1; rd_en = 1'b1; rd_sel = 2'd2; rd_hi = 1'b0;
    tick();
    rst = 1'b0; rd_en = 1'b0; set_inc(3, 2'd0);
    rd("rst2_ctr2_lo", 2'd2, 1'b0, 32'h0);
    rd("rst2_ctr3_hi", 2'd3, 1'b1, 32'h0);
    check("ovf_rst2", 64'(overflow), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
